// File: rtl/bc_io_pkg.sv
// Shared definitions for the basic-computer serial I/O ports (input and output).
package bc_io_pkg;

    localparam int DATA_BITS = 8;
    localparam int INPR_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } port_state_e;

endpackage : bc_io_pkg

// File: rtl/bc_sync2.sv
// Two-flop synchronizer for an asynchronous line that idles high.
module bc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : bc_sync2

// File: rtl/bc_input_port.sv
// 8N1 serial receiver feeding the processor's INPR register and FGI flag,
// with sticky overrun and framing error flags.
module bc_input_port
    import bc_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              clr_fgi,
    input  logic              err_clr,
    output logic [INPR_W-1:0] INPR,
    output logic              FGI,
    output logic              ovr_err,
    output logic              frm_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic rxs;

    port_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 deliver_q, deliver_d;
    logic                 bad_stop_q, bad_stop_d;
    logic [INPR_W-1:0]    inpr_q, inpr_d;
    logic                 fgi_q, fgi_d;
    logic                 ovr_q, ovr_d;
    logic                 frm_q, frm_d;

    bc_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        deliver_d  = 1'b0;
        bad_stop_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) state_d = STOP;
                    else                   bit_d   = bit_q + BIT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                // The verdict is registered here and applied to the flags one edge later.
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        deliver_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bad_stop_d = 1'b1;
                        state_d    = WAIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inpr_d = inpr_q;
        fgi_d  = clr_fgi ? 1'b0 : fgi_q;
        ovr_d  = err_clr ? 1'b0 : ovr_q;
        frm_d  = err_clr ? 1'b0 : frm_q;

        // A read retiring in the same cycle frees INPR, so the new byte is accepted.
        if (deliver_q) begin
            if (!fgi_q || clr_fgi) begin
                inpr_d = shift_q;
                fgi_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (bad_stop_q) frm_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            deliver_q  <= 1'b0;
            bad_stop_q <= 1'b0;
            inpr_q     <= '0;
            fgi_q      <= 1'b0;
            ovr_q      <= 1'b0;
            frm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            deliver_q  <= deliver_d;
            bad_stop_q <= bad_stop_d;
            inpr_q     <= inpr_d;
            fgi_q      <= fgi_d;
            ovr_q      <= ovr_d;
            frm_q      <= frm_d;
        end
    end

    assign INPR    = inpr_q;
    assign FGI     = fgi_q;
    assign ovr_err = ovr_q;
    assign frm_err = frm_q;

endmodule : bc_input_port

// File: tb/tb_bc_input_port.sv
// Self-checking bench for bc_input_port: directed frames followed by random
// frames, compared against a frame-level model of INPR and the flags.
module tb_bc_input_port;

    localparam int CPB       = 16;
    localparam int FRAME_LEN = 10 * CPB;
    localparam int LATENCY   = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       clr_fgi = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] inpr;
    logic       fgi;
    logic       ovr_err;
    logic       frm_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model of the processor-visible state.
    logic [7:0] m_inpr = 8'h00;
    logic       m_fgi  = 1'b0;
    logic       m_ovr  = 1'b0;
    logic       m_frm  = 1'b0;

    always #5 clk = ~clk;

    bc_input_port #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .clr_fgi (clr_fgi),
        .err_clr (err_clr),
        .INPR    (inpr),
        .FGI     (fgi),
        .ovr_err (ovr_err),
        .frm_err (frm_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".INPR"},    inpr,             m_inpr);
        check({tag, ".FGI"},     {7'd0, fgi},      {7'd0, m_fgi});
        check({tag, ".ovr_err"}, {7'd0, ovr_err},  {7'd0, m_ovr});
        check({tag, ".frm_err"}, {7'd0, frm_err},  {7'd0, m_frm});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_inpr = 8'h00;
        m_fgi  = 1'b0;
        m_ovr  = 1'b0;
        m_frm  = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_fgi = 1'b1;
        tick();
        clr_fgi = 1'b0;
        m_fgi   = 1'b0;
        check("clr_fgi.FGI", {7'd0, fgi}, 8'd0);
    endtask

    task automatic pulse_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_ovr   = 1'b0;
        m_frm   = 1'b0;
        check("err_clr.ovr", {7'd0, ovr_err}, 8'd0);
        check("err_clr.frm", {7'd0, frm_err}, 8'd0);
    endtask

    // Transmits one frame; cycle c of the loop ends on the edge c cycles after
    // the first edge that samples the start bit. abort_at >= 0 pulses reset there.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit clr_at_dlv,
                              input bit chk_lat, input int abort_at);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int c = 0; c < FRAME_LEN; c++) begin
            if (c == abort_at) begin
                rst_n   = 1'b0;
                rx      = 1'b1;
                clr_fgi = 1'b0;
                tick();
                rst_n = 1'b1;
                model_reset();
                return;
            end
            rx      = bits[c / CPB];
            clr_fgi = clr_at_dlv && (c == LATENCY);
            tick();
            if (chk_lat && c == LATENCY - 1)
                check("latency.FGI_before", {7'd0, fgi}, 8'd0);
            if (chk_lat && c == LATENCY) begin
                check("latency.FGI_at", {7'd0, fgi}, 8'd1);
                check("latency.INPR_at", inpr, b);
            end
        end
        clr_fgi = 1'b0;
        rx      = 1'b1;
        if (!stop_ok) begin
            m_frm = 1'b1;
        end else if (!m_fgi || clr_at_dlv) begin
            m_inpr = b;
            m_fgi  = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
        repeat (4) tick();
    endtask

    initial begin
        logic [7:0] rb;
        bit         r_stop;
        bit         r_clr_dlv;

        // Reset state
        repeat (3) tick();
        check_all("reset");
        rst_n = 1'b1;
        tick();

        // Basic reception with exact latency
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1);
        check_all("a5");

        // Read-then-receive and overrun
        pulse_clr();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1);
        check_all("3c");
        pulse_clr();
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, -1);
        check_all("81");
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, -1);
        check_all("55_overrun");

        // Framing error, then recovery
        pulse_err();
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, -1);
        check_all("7e_frm");
        pulse_clr();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
        check_all("11_after_frm");

        // Start-bit glitch
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (20) tick();
        check_all("glitch");

        // Read and delivery on the same edge while FGI=1
        pulse_err();
        send_frame(8'h42, 1'b1, 1'b1, 1'b0, -1);
        check_all("42_clr_same");

        // Reset in the middle of the data bits, then a clean frame
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 5 * CPB - 4);
        check_all("ff_reset");
        tick();
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0, -1);
        check_all("0f_after_rst");

        // Random traffic
        for (int i = 0; i < 12; i++) begin
            rb        = 8'($urandom);
            r_stop    = ($urandom_range(0, 4) != 0);
            r_clr_dlv = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 1) pulse_clr();
            if ($urandom_range(0, 3) == 0) pulse_err();
            send_frame(rb, r_stop, r_clr_dlv, 1'b0, -1);
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bc_input_port
